// File: rtl/hyperbus_wb_bridge.sv
// hyperbus_wb_bridge
// Wishbone classic 32-bit slave that turns every single access into a
// two-word (16-bit) linear burst on the hyperbus controller request
// interface, with a per-access timeout that converts a stalled memory into
// a Wishbone error instead of a hung bus.
//
// Ports:
//   clk, rst          controller clock, synchronous active-high reset
//   wb_*_i / wb_*_o   Wishbone classic slave (32-bit data, 4 byte enables)
//   hb_adr_o          word address to the controller (ADDR_LENGTH bits)
//   hb_dat_o          write word, hb_mask_o RWDS mask (1 = byte masked)
//   hb_reg_space_o    register-space select
//   hb_wrq_o/hb_rrq_o write/read request, held for the whole burst
//   hb_dat_i          read word, hb_ready_i write word accepted,
//   hb_valid_i        read word valid, hb_busy_i controller not idle,
//   hb_error_i        controller in error state
module hyperbus_wb_bridge #(
    parameter int ADDR_LENGTH   = 32,
    parameter int REG_SPACE_BIT = 31,
    parameter int TIMEOUT_COUNT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [ADDR_LENGTH-1:0] hb_adr_o,
    output logic [15:0]            hb_dat_o,
    output logic [2:0]             hb_mask_o,
    output logic                   hb_reg_space_o,
    output logic                   hb_wrq_o,
    output logic                   hb_rrq_o,
    input  logic [15:0]            hb_dat_i,
    input  logic                   hb_ready_i,
    input  logic                   hb_valid_i,
    input  logic                   hb_busy_i,
    input  logic                   hb_error_i
);

    localparam int TW = (TIMEOUT_COUNT < 2) ? 1 : $clog2(TIMEOUT_COUNT + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_COUNT);

    typedef enum logic [2:0] {IDLE, WR0, WR1, RD0, RD1, DRAIN, RESP} state_t;

    state_t                 r_state,    w_stateNext;
    logic [TW-1:0]          r_timer,    w_timerNext;
    logic [ADDR_LENGTH-1:0] r_adr,      w_adrNext;
    logic                   r_regSpace, w_regSpaceNext;
    logic [31:0]            r_wdat,     w_wdatNext;
    logic [3:0]             r_sel,      w_selNext;
    logic                   r_isRead,   w_isReadNext;
    logic                   r_wrq,      w_wrqNext;
    logic                   r_rrq,      w_rrqNext;
    logic                   r_errFlag,  w_errFlagNext;
    logic                   r_cycLost,  w_cycLostNext;
    logic [31:0]            r_rbuf,     w_rbufNext;
    logic [31:0]            r_datO,     w_datONext;
    logic                   r_ack,      w_ackNext;
    logic                   r_err,      w_errNext;

    logic [ADDR_LENGTH:0]   w_adrExt;
    logic [ADDR_LENGTH-1:0] w_hbAdr;
    logic                   w_cycLostNow;
    logic                   w_expire;
    logic [15:0]            w_hbDat;
    logic [2:0]             w_hbMask;
    logic                   w_unused;

    // Byte address -> 16-bit word address. The register-space bit is cleared
    // in the byte address before the shift, and the lowest word bit is forced
    // to 0 so every burst starts 32-bit aligned.
    always_comb begin
        w_adrExt = (ADDR_LENGTH + 1)'(wb_adr_i);
        w_adrExt[REG_SPACE_BIT] = 1'b0;
        w_hbAdr = {w_adrExt[ADDR_LENGTH:2], 1'b0};
    end

    assign w_unused = ^w_adrExt[1:0];

    // Next-state and next-output logic. Every register has a "next" value;
    // the expiry condition (timer reached or controller error) aborts the
    // burst into DRAIN, and a second expiry in DRAIN forces the response.
    always_comb begin
        w_stateNext    = r_state;
        w_timerNext    = r_timer;
        w_adrNext      = r_adr;
        w_regSpaceNext = r_regSpace;
        w_wdatNext     = r_wdat;
        w_selNext      = r_sel;
        w_isReadNext   = r_isRead;
        w_wrqNext      = r_wrq;
        w_rrqNext      = r_rrq;
        w_errFlagNext  = r_errFlag;
        w_cycLostNext  = r_cycLost;
        w_rbufNext     = r_rbuf;
        w_datONext     = r_datO;
        w_ackNext      = 1'b0;
        w_errNext      = 1'b0;
        w_cycLostNow   = r_cycLost | ~wb_cyc_i;
        w_expire       = (r_timer == TIMEOUT_VAL) | hb_error_i;

        case (r_state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i && !hb_busy_i && !r_ack && !r_err) begin
                    w_adrNext      = w_hbAdr;
                    w_regSpaceNext = wb_adr_i[REG_SPACE_BIT];
                    w_wdatNext     = wb_dat_i;
                    w_selNext      = wb_sel_i;
                    w_isReadNext   = ~wb_we_i;
                    w_timerNext    = '0;
                    w_cycLostNext  = 1'b0;
                    if (hb_error_i) begin
                        w_errFlagNext = 1'b1;
                        w_stateNext   = RESP;
                    end else begin
                        w_errFlagNext = 1'b0;
                        if (wb_we_i) begin
                            w_wrqNext   = 1'b1;
                            w_stateNext = WR0;
                        end else begin
                            w_rrqNext   = 1'b1;
                            w_stateNext = RD0;
                        end
                    end
                end
            end
            WR0, WR1, RD0, RD1: begin
                w_cycLostNext = w_cycLostNow;
                if (w_expire) begin
                    w_wrqNext     = 1'b0;
                    w_rrqNext     = 1'b0;
                    w_errFlagNext = 1'b1;
                    w_timerNext   = '0;
                    w_stateNext   = DRAIN;
                end else begin
                    w_timerNext = r_timer + 1'b1;
                    case (r_state)
                        WR0: if (hb_ready_i) w_stateNext = WR1;
                        WR1: if (hb_ready_i) begin
                            w_wrqNext   = 1'b0;
                            w_stateNext = DRAIN;
                        end
                        RD0: if (hb_valid_i) begin
                            w_rbufNext[15:0] = hb_dat_i;
                            w_stateNext      = RD1;
                        end
                        RD1: if (hb_valid_i) begin
                            w_rbufNext[31:16] = hb_dat_i;
                            w_rrqNext         = 1'b0;
                            w_stateNext       = DRAIN;
                        end
                        default: ;
                    endcase
                end
            end
            DRAIN: begin
                w_cycLostNext = w_cycLostNow;
                if (w_expire) begin
                    w_errFlagNext = 1'b1;
                    w_stateNext   = RESP;
                end else if (!hb_busy_i) begin
                    w_stateNext = RESP;
                end else begin
                    w_timerNext = r_timer + 1'b1;
                end
            end
            RESP: begin
                // A master that abandoned the cycle gets no pulse at all.
                w_ackNext = ~w_cycLostNow & ~r_errFlag;
                w_errNext = ~w_cycLostNow & r_errFlag;
                if (w_ackNext && r_isRead) w_datONext = r_rbuf;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Write word/mask follow the burst phase; idle phases present zeros.
    always_comb begin
        w_hbDat  = '0;
        w_hbMask = '0;
        case (r_state)
            WR0: begin
                w_hbDat  = r_wdat[15:0];
                w_hbMask = {1'b0, ~r_sel[1], ~r_sel[0]};
            end
            WR1: begin
                w_hbDat  = r_wdat[31:16];
                w_hbMask = {1'b0, ~r_sel[3], ~r_sel[2]};
            end
            default: ;
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_adr      <= '0;
            r_regSpace <= 1'b0;
            r_wdat     <= '0;
            r_sel      <= '0;
            r_isRead   <= 1'b0;
            r_wrq      <= 1'b0;
            r_rrq      <= 1'b0;
            r_errFlag  <= 1'b0;
            r_cycLost  <= 1'b0;
            r_rbuf     <= '0;
            r_datO     <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_timer    <= w_timerNext;
            r_adr      <= w_adrNext;
            r_regSpace <= w_regSpaceNext;
            r_wdat     <= w_wdatNext;
            r_sel      <= w_selNext;
            r_isRead   <= w_isReadNext;
            r_wrq      <= w_wrqNext;
            r_rrq      <= w_rrqNext;
            r_errFlag  <= w_errFlagNext;
            r_cycLost  <= w_cycLostNext;
            r_rbuf     <= w_rbufNext;
            r_datO     <= w_datONext;
            r_ack      <= w_ackNext;
            r_err      <= w_errNext;
        end
    end

    assign wb_dat_o       = r_datO;
    assign wb_ack_o       = r_ack;
    assign wb_err_o       = r_err;
    assign hb_adr_o       = r_adr;
    assign hb_dat_o       = w_hbDat;
    assign hb_mask_o      = w_hbMask;
    assign hb_reg_space_o = r_regSpace;
    assign hb_wrq_o       = r_wrq;
    assign hb_rrq_o       = r_rrq;

endmodule

// File: doc/hyperbus_wb_bridge.md
Name: hyperbus_wb_bridge

Overview:
Wishbone classic 32-bit slave that converts each single bus access into a two-word (16-bit) linear burst on the hyperbus controller request interface. It sits directly upstream of the hyperbus controller: it drives the address, write data, mask and request lines, and it consumes the ready, valid, busy and error outputs. It adds a per-access timeout so that a stalled memory produces a bus error instead of hanging the bus.

Parameters:
ADDR_LENGTH, 32, width of the controller word address (hb_adr_o)
REG_SPACE_BIT, 31, wb_adr_i bit that selects HyperRAM register space
TIMEOUT_COUNT, 255, maximum cycles from request assertion to completion before an error is raised

Ports:
clk  in  1  controller clock (same clock as hyperbus clk)
rst  in  1  synchronous, active-high reset
wb_adr_i  in  32  byte address; bits [1:0] ignored
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte enables
wb_we_i  in  1  1 = write
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  one-cycle acknowledge
wb_err_o  out  1  one-cycle error
hb_adr_o  out  ADDR_LENGTH  word address to controller
hb_dat_o  out  16  write word to controller
hb_mask_o  out  3  RWDS write mask; 1 = byte masked; bit 2 always 0
hb_reg_space_o  out  1  register-space select
hb_wrq_o  out  1  write request, held for the whole burst
hb_rrq_o  out  1  read request, held for the whole burst
hb_dat_i  in  16  read word from controller
hb_ready_i  in  1  controller accepts a write word this cycle
hb_valid_i  in  1  read word valid this cycle
hb_busy_i  in  1  controller not idle
hb_error_i  in  1  controller in error state

Behaviour:
- Reset (synchronous, rst=1 on a clk edge) forces the following values, and all outputs hold them on the next cycle. This applies mid-transaction too; no burst completion is attempted.
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - hb_wrq_o=0, hb_rrq_o=0, hb_adr_o=0, hb_dat_o=0, hb_mask_o=0, hb_reg_space_o=0.
  - state=IDLE, timer=0.
- Address mapping: hb_adr_o = wb_adr_i[ADDR_LENGTH:1] with the REG_SPACE_BIT position forced to 0 and bit 0 forced to 0. hb_reg_space_o = wb_adr_i[REG_SPACE_BIT]. All of these are latched at request.
- Word order: word0 = bytes 1:0 and word1 = bytes 3:2.
  - word0 mask = {0, ~wb_sel_i[1], ~wb_sel_i[0]}.
  - word1 mask = {0, ~wb_sel_i[3], ~wb_sel_i[2]}.
- IDLE:
  - Accept a request when wb_cyc_i & wb_stb_i & !hb_busy_i & !wb_ack_o & !wb_err_o.
  - On accept, latch address, sel and data; clear the timer.
  - If hb_error_i=1 at accept, go to RESP with error and no request issued.
  - Otherwise assert hb_wrq_o or hb_rrq_o (per wb_we_i) on the next cycle and go to WR0 or RD0.
- WR0: hb_dat_o=word0, hb_mask_o=mask0. On hb_ready_i=1, go to WR1.
- WR1: hb_dat_o=word1, hb_mask_o=mask1. On hb_ready_i=1, deassert hb_wrq_o on the next cycle and go to DRAIN.
  - Net effect: exactly two ready cycles are consumed per write.
- RD0: on hb_valid_i=1, capture hb_dat_i into rdata[15:0] and go to RD1.
- RD1: on hb_valid_i=1, capture hb_dat_i into rdata[31:16], deassert hb_rrq_o on the next cycle and go to DRAIN.
  - Any further valid pulses are ignored.
- DRAIN: wait for hb_busy_i=0, then go to RESP.
- RESP: drive wb_ack_o (or wb_err_o) high for exactly one cycle, then return to IDLE.
  - For reads, wb_dat_o = rdata, registered and held until the next read ack.
  - The ack is suppressed (no pulse at all) if wb_cyc_i dropped at any point during the transaction. The HyperBus burst still completes.
- Timeout:
  - The timer counts every cycle in WR0, WR1, RD0, RD1 and DRAIN.
  - When timer == TIMEOUT_COUNT, drop both requests, flag an error and go to DRAIN.
  - If busy never clears, DRAIN exits via a second TIMEOUT_COUNT expiry to RESP with error.
  - hb_error_i=1 in any non-IDLE state has the same effect as a timeout expiry.
- hb_wrq_o and hb_rrq_o are never both 1. Neither is asserted while hb_busy_i=1 from a previous burst.
- Minimum latency, write: request to first ready ≥ 1 cycle, plus 2 ready cycles, plus DRAIN, plus ack.

Test Plan:
1. Write with wb_adr_i=0x0000_0010, dat=0xA1B2C3D4, sel=0xF; model asserts ready for 2 cycles -> hb_adr_o=0x8, hb_reg_space_o=0, hb_dat_o sequence 0xC3D4 then 0xA1B2, masks 0 and 0, hb_wrq_o drops after the 2nd ready, then one wb_ack_o pulse.
2. Write with sel=0x6 -> mask0=3'b001, mask1=3'b010.
3. Read at 0x8000_0004; model returns valid words 0x1111 then 0x2222 with 3 idle cycles between them -> hb_reg_space_o=1, hb_adr_o=0x2, wb_dat_o=0x22221111 on the ack cycle.
4. Read where the model never asserts valid; TIMEOUT_COUNT=16 -> hb_rrq_o drops after 16 counted cycles, one wb_err_o pulse, no ack.
5. wb_cyc_i deasserted during WR0 -> burst completes with 2 ready cycles, no ack/err pulse, and the next access is accepted normally.
6. rst asserted during RD1 -> all outputs at reset values on the next cycle; a new read after hb_busy_i falls completes correctly.
